// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit.
// Contents:
//   WIDTH_DEF      default operand/result width
//   MUL_* op codes RV32M multiply-group encodings carried on the op input
//   state_t        sequencer states of the iterative multiplier
package mul_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] MUL_LO  = 2'b00;  // MUL    : low half, sign irrelevant
  localparam logic [1:0] MUL_HSS = 2'b01;  // MULH   : high half, signed x signed
  localparam logic [1:0] MUL_HSU = 2'b10;  // MULHSU : high half, signed x unsigned
  localparam logic [1:0] MUL_HUU = 2'b11;  // MULHU  : high half, unsigned x unsigned

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the execute stage and the multiplier.
// Signals:
//   start        request, sampled only while the unit is idle
//   op           operation select (see mul_pkg op codes)
//   multiplicand rs1 operand
//   multiplier   rs2 operand
//   result       selected product half, held until the next accepted start
//   ready        high only while idle; the pipeline stalls while low
//   done         one-cycle pulse when result becomes valid
// Modports: master = requester (pipeline), slave = multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = mul_pkg::WIDTH_DEF
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             done;

  modport master (
    output start, op, multiplicand, multiplier,
    input  result, ready, done
  );

  modport slave (
    input  start, op, multiplicand, multiplier,
    output result, ready, done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to unsigned magnitudes on acceptance, multiplied over
// WIDTH iterations of one add + shift, and the sign is restored in one extra
// cycle. Fixed latency; no early exit.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; forces IDLE and clears all state
//   bus    seq_multiplier_if slave modport (start/op/operands in,
//          result/ready/done out)
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  seq_multiplier_if.slave bus
);

  // Two's complement at full product width; operand magnitudes use the low
  // WIDTH bits of the same operation.
  function automatic logic [2*WIDTH-1:0] twos_neg(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   mcand_reg;   // multiplicand, shifted to current bit weight
  logic [WIDTH-1:0]     mplier_reg;  // multiplier, consumed LSB first
  logic [CNT_W-1:0]     count_reg;
  logic                 neg_reg;
  logic [1:0]           op_reg;
  logic [WIDTH-1:0]     result_reg;

  logic                 a_signed, b_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_fixed;

  // Operand conditioning from the live request inputs (used only at acceptance).
  always_comb begin
    a_signed = (bus.op == MUL_HSS) || (bus.op == MUL_HSU);
    b_signed = (bus.op == MUL_HSS);
    a_neg    = a_signed && bus.multiplicand[WIDTH-1];
    b_neg    = b_signed && bus.multiplier[WIDTH-1];
    a_mag    = a_neg ? WIDTH'(twos_neg({{WIDTH{1'b0}}, bus.multiplicand})) : bus.multiplicand;
    b_mag    = b_neg ? WIDTH'(twos_neg({{WIDTH{1'b0}}, bus.multiplier}))   : bus.multiplier;
  end

  always_comb begin
    acc_fixed = neg_reg ? twos_neg(acc_reg) : acc_reg;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = RUN;
      // count still holds 1 on the last iteration edge; it reaches 0 with it
      RUN:  if (count_reg == CNT_W'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only: no combinational path from inputs.
  always_comb begin
    bus.ready = (state_reg == IDLE);
    bus.done  = (state_reg == DONE);
  end

  assign bus.result = result_reg;

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      op_reg     <= MUL_LO;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg     <= bus.op;
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            neg_reg    <= a_neg ^ b_neg;
            acc_reg    <= '0;
            count_reg  <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg - CNT_W'(1);
        end
        FIX: begin
          acc_reg    <= acc_fixed;
          result_reg <= (op_reg == MUL_LO) ? acc_fixed[WIDTH-1:0]
                                           : acc_fixed[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: hand-computed products, latency,
// ready/done behaviour, ignored mid-operation requests and async reset abort.
module tb_seq_multiplier;
  import mul_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: request at a negedge, accepted at E0, then observe
  // 36 edges. If ign_at > 0, a conflicting start is pulsed after edge ign_at.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int ign_at);
    int done_edge = -1;
    int pulses    = 0;
    int ready_bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.multiplicand = a;
    bus.multiplier = b;
    @(posedge clk);
    #1;
    // scramble inputs after acceptance; they must not matter
    bus.start = 1'b0;
    bus.op = ~op;
    bus.multiplicand = ~a;
    bus.multiplier = ~b;
    if (bus.ready !== 1'b0) ready_bad++;
    for (int n = 1; n <= 36; n++) begin
      if (n == ign_at) begin
        bus.start = 1'b1;
        bus.op = MUL_HUU;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'd9;
      end
      if (n == ign_at + 2) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (n <= 33 && bus.ready !== 1'b0) ready_bad++;
      if (n >= 34 && bus.ready !== 1'b1) ready_bad++;
    end
    bus.start = 1'b0;
    $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h done_edge=%0d pulses=%0d",
             tag, op, a, b, bus.result, done_edge, pulses);
    check({tag, " result"}, bus.result, exp);
    check({tag, " done_edge"}, 32'(done_edge), 32'd33);
    check({tag, " done_pulses"}, 32'(pulses), 32'd1);
    check({tag, " ready_bad"}, 32'(ready_bad), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.op = MUL_LO;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #2;
    check("reset result", bus.result, 32'h0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset ready", 32'(bus.ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("mul_7x6",      MUL_LO,  32'd7,         32'd6,         32'h0000002A, 0);
    run_op("mul_ffxff",    MUL_LO,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 0);
    run_op("mulhu_ffxff",  MUL_HUU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 0);
    run_op("mulh_min2",    MUL_HSS, 32'h80000000,  32'h80000000,  32'h40000000, 0);
    run_op("mulh_m1x1",    MUL_HSS, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 0);
    run_op("mulhsu_ffxff", MUL_HSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 0);
    run_op("mulhsu_2x8",   MUL_HSU, 32'h00000002,  32'h80000000,  32'h00000001, 0);
    run_op("mul_zero",     MUL_LO,  32'h00000000,  32'h12345678,  32'h00000000, 0);
    run_op("mulh_m2xm3",   MUL_HSS, 32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000000, 0);
    run_op("mul_m2xm3",    MUL_LO,  32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000006, 0);
    run_op("mul_ignore",   MUL_LO,  32'd3,         32'd5,         32'h0000000F, 10);

    // Async reset mid-RUN: abort with no partial result
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MUL_HUU;
    bus.multiplicand = 32'hFFFFFFFF;
    bus.multiplier = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    $display("txn reset_mid result=0x%08h done=%0b ready=%0b", bus.result, bus.done, bus.ready);
    check("abort result", bus.result, 32'h0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul_2p16sq",   MUL_LO,  32'h00010000,  32'h00010000,  32'h00000000, 0);
    run_op("mulhu_2p16sq", MUL_HUU, 32'h00010000,  32'h00010000,  32'h00000001, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
